// File: rtl/i2c_slave_write_byte.sv
// Slave-side I2C byte transmitter: shifts one byte out on SDA MSB-first in step
// with master SCL, releases SDA for the ACK clock and samples the master's ACK.
module i2c_slave_write_byte #(
  parameter int unsigned BIT_NUM = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               byte_write_en,
  input  logic [BIT_NUM-1:0] byte_write_i,
  output logic               byte_write_ack,
  output logic               byte_write_err,
  output logic               byte_write_finish,
  input  logic               scl_i,
  input  logic               sda_i,
  output logic               sda_o
);

  localparam int unsigned CNT_W = (BIT_NUM > 1) ? $clog2(BIT_NUM) : 1;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    ACK
  } state_t;

  state_t             state;
  logic               scl_last;
  logic [BIT_NUM-1:0] shreg;
  logic [CNT_W-1:0]   cnt;
  logic               scl_rise;
  logic               scl_fall;

  assign scl_rise = ~scl_last & scl_i;
  assign scl_fall = scl_last & ~scl_i;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state             <= IDLE;
      scl_last          <= 1'b1;
      shreg             <= '0;
      cnt               <= '0;
      sda_o             <= 1'b1;
      byte_write_ack    <= 1'b0;
      byte_write_err    <= 1'b0;
      byte_write_finish <= 1'b0;
    end else begin
      scl_last          <= scl_i;
      byte_write_err    <= 1'b0;
      byte_write_finish <= 1'b0;

      case (state)
        IDLE: begin
          sda_o <= 1'b1;
          if (byte_write_en) begin
            // Starting while SCL is high would change SDA mid-bit, so refuse it.
            if (!scl_i) begin
              shreg          <= byte_write_i;
              cnt            <= CNT_W'(BIT_NUM - 1);
              sda_o          <= byte_write_i[BIT_NUM-1];
              byte_write_ack <= 1'b0;
              state          <= DATA;
            end else begin
              byte_write_err <= 1'b1;
            end
          end
        end

        DATA: begin
          if (scl_fall) begin
            if (cnt != '0) begin
              cnt   <= cnt - CNT_W'(1);
              sda_o <= shreg[cnt - CNT_W'(1)];
            end else begin
              sda_o <= 1'b1;
              state <= ACK;
            end
          end else if (scl_i && !scl_rise && (sda_i != sda_o)) begin
            // Bus level disagrees with our drive while SCL is high: another
            // driver or a master START/STOP. Back off and report.
            sda_o          <= 1'b1;
            byte_write_err <= 1'b1;
            state          <= IDLE;
          end
        end

        ACK: begin
          sda_o <= 1'b1;
          if (scl_rise) begin
            byte_write_ack <= ~sda_i;
          end else if (scl_fall) begin
            byte_write_finish <= 1'b1;
            state             <= IDLE;
          end
        end

        default: begin
          sda_o <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/i2c_slave_write_byte.md
# i2c_slave_write_byte

Slave-side I2C byte transmitter: on request, shifts one byte out on SDA MSB-first, synchronised to master-generated SCL, then releases SDA for the 9th clock and samples the master's ACK/NACK. It is the transmit counterpart of the slave bit/byte receive path and sits under the slave controller FSM, which issues it for master-read transfers. Open-drain SDA and SCL pads are outside this block; sda_i is the resolved bus level (wired-AND of all drivers).

## Interface

- BIT_NUM, 8, data bits per transfer (MSB sent first); ACK slot follows as clock BIT_NUM+1

- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  synchronous active-low reset
- byte_write_en  input  1  one-cycle start pulse; sampled only in IDLE
- byte_write_i  input  BIT_NUM  data to transmit, captured with byte_write_en
- byte_write_ack  output  1  1 = master ACKed (SDA low on 9th SCL rise); held until next accepted start
- byte_write_err  output  1  one-cycle pulse: bus conflict or illegal start
- byte_write_finish  output  1  one-cycle pulse: transfer incl. ACK slot complete
- scl_i  input  1  SCL bus level
- sda_i  input  1  SDA bus level
- sda_o  output  1  SDA drive: 0 = pull low, 1 = release

## Operation

- Edge detect: scl_last register (reset 1); scl_rise = ~scl_last & scl_i, scl_fall = scl_last & ~scl_i, computed on current inputs.
- States: IDLE, DATA, ACK.
- IDLE: sda_o = 1. byte_write_en with scl_i = 0 -> capture byte into shift register, bit counter = BIT_NUM-1, sda_o = MSB, clear byte_write_ack, go DATA. byte_write_en with scl_i = 1 -> pulse byte_write_err, stay IDLE, sda_o stays 1. byte_write_en in DATA/ACK is ignored.
- DATA: on scl_fall, counter > 0 -> decrement, drive next bit; counter = 0 -> sda_o = 1, go ACK. While scl_i = 1 (excluding the scl_rise cycle itself), sda_i != sda_o -> conflict (another driver, or START/STOP from master): sda_o = 1, pulse byte_write_err, go IDLE, no finish.
- ACK: sda_o = 1. On scl_rise, byte_write_ack <= ~sda_i. On the following scl_fall, pulse byte_write_finish, go IDLE. No conflict check in ACK (master owns SDA).
- Reset: sda_o = 1, byte_write_ack = 0, byte_write_err = 0, byte_write_finish = 0, scl_last = 1, state IDLE, shift register and counter 0. Reset mid-transfer aborts immediately with SDA released.

## Timing

- All outputs registered. byte_write_en at cycle N (SCL low) -> sda_o = MSB at cycle N+1.
- scl_fall detected at cycle F (first cycle scl_i = 0) -> new sda_o visible at F+1; SDA therefore changes one clk after SCL falls, always while SCL low.
- byte_write_err: cycle after the offending sample / illegal enable; exactly one cycle.
- byte_write_finish: cycle after the 9th SCL fall detection; exactly one cycle; byte_write_ack already valid in that cycle.
- Back-to-back: byte_write_en in the cycle byte_write_finish is high (state already IDLE, SCL low) is accepted; next MSB drives one cycle later.
- Minimum SCL low/high phase: 2 clk each.

## Test plan

- Send 0xA5, bench (SCL = clk/8) returns ACK -> sda_o sampled on SCL rises 1,0,1,0,0,1,0,1; sda_o = 1 through 9th clock; byte_write_ack = 1; one finish pulse; no err.
- Send 0x3C, bench leaves SDA high on 9th clock -> bits 0,0,1,1,1,1,0,0; byte_write_ack = 0; one finish pulse.
- Send 0xFF, bench pulls sda_i = 0 during SCL high of bit 2 -> byte_write_err pulse one clk later, sda_o = 1 thereafter, no finish; next enable accepted normally.
- byte_write_en with scl_i = 1 -> byte_write_err next cycle, sda_o remains 1, state IDLE, byte_write_ack unchanged.
- Send 0x13, assert rst_n = 0 for one cycle during bit 4 -> next cycle sda_o = 1, all outputs 0; subsequent 0x57 transfers correctly with ACK.
- Back-to-back 0x13 then 0x57, second enable in the finish cycle -> 16 correct bits, two ACKs sampled, two finish pulses, no err.
